// File: rtl/gsu_pkg.sv
// rtl/gsu_pkg.sv - shared constants and read-FSM state type for the GSU MMIO front end
package gsu_pkg;
    localparam logic [9:0] ADDR_R15_HI     = 10'h01F;
    localparam logic [9:0] ADDR_SFR_L      = 10'h030;
    localparam logic [9:0] ADDR_SFR_H      = 10'h031;
    localparam logic [9:0] ADDR_BRAMR      = 10'h033;
    localparam logic [9:0] ADDR_PBR        = 10'h034;
    localparam logic [9:0] ADDR_ROMBR      = 10'h036;
    localparam logic [9:0] ADDR_CFGR       = 10'h037;
    localparam logic [9:0] ADDR_SCBR       = 10'h038;
    localparam logic [9:0] ADDR_CLSR       = 10'h039;
    localparam logic [9:0] ADDR_SCMR       = 10'h03A;
    localparam logic [9:0] ADDR_VCR        = 10'h03B;
    localparam logic [9:0] ADDR_RAMBR      = 10'h03C;
    localparam logic [9:0] ADDR_CBR_L      = 10'h03E;
    localparam logic [9:0] ADDR_CBR_H      = 10'h03F;
    localparam logic [9:0] ADDR_CACHE_BASE = 10'h100;

    localparam int SFR_GO        = 5;
    localparam int SFR_IRQ       = 15;
    localparam int CFGR_IRQ_MASK = 7;

    localparam logic [7:0] VCR_VALUE = 8'h04;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_REG,
        RD_CACHE,
        RD_HOLD
    } rd_state_t;
endpackage

// File: rtl/gsu_cache_dp.sv
// rtl/gsu_cache_dp.sv - dual-port instruction cache RAM, read-first, synchronous read
module gsu_cache_dp #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_rdata
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        a_rdata <= mem[a_addr];
    end

    // Port B sees the pre-write contents when it collides with a port A write.
    always_ff @(posedge clk) begin
        b_rdata <= mem[b_addr];
    end
endmodule

// File: rtl/gsu_mmio.sv
// rtl/gsu_mmio.sv - SNES-side MMIO front end: GPRs, special registers, cache port
module gsu_mmio
    import gsu_pkg::*;
#(
    parameter int NUM_GPR  = 16,
    parameter int CACHE_AW = 9
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic                SNES_RD_start,
    input  logic                SNES_WR_end,
    input  logic [23:0]         SNES_ADDR,
    input  logic [7:0]          DATA_IN,
    output logic                DATA_ENABLE,
    output logic [7:0]          DATA_OUT,
    input  logic [3:0]          CORE_RD_ADDR,
    output logic [15:0]         CORE_RD_DATA,
    input  logic                CORE_WE,
    input  logic [3:0]          CORE_WADDR,
    input  logic [15:0]         CORE_WDATA,
    input  logic                CORE_CBR_WE,
    input  logic [15:0]         CORE_CBR_DATA,
    input  logic                CORE_STOP,
    input  logic [CACHE_AW-1:0] CACHE_CORE_ADDR,
    output logic [7:0]          CACHE_CORE_RDATA,
    output logic                GO,
    output logic                IRQ,
    output logic [7:0]          PBR,
    output logic [15:0]         CBR
);
    localparam int GW = $clog2(NUM_GPR);

    logic [15:0] gpr [NUM_GPR];
    logic [15:0] sfr, cbr_r, cache_off;
    logic [7:0]  bramr, pbr_r, rombr, cfgr, scbr, clsr, scmr, rambr, wr_flop;
    logic [7:0]  reg_rdata, cache_a_rdata, data_out;
    logic [9:0]  addr;
    logic [GW-1:0] gpr_idx;
    logic [CACHE_AW-1:0] cache_idx;
    logic is_gpr, is_cache, snes_wr, gpr_wr, cache_wr, rd_accept, cache_blocked;
    logic unused_ok;
    rd_state_t state, state_nx;

    assign addr      = SNES_ADDR[9:0];
    assign gpr_idx   = addr[GW:1];
    assign is_gpr    = (addr[9:5] == 5'd0);
    assign is_cache  = (addr[9:8] == 2'b01) || (addr[9:8] == 2'b10);
    assign snes_wr   = SNES_WR_end & ENABLE;
    assign gpr_wr    = snes_wr & is_gpr & ~sfr[SFR_GO];
    assign cache_wr  = snes_wr & is_cache & ~sfr[SFR_GO];
    assign rd_accept = (state == RD_IDLE) & SNES_RD_start & ENABLE & ~SNES_WR_end;
    assign cache_off = {6'd0, addr} - {6'd0, ADDR_CACHE_BASE} + cbr_r;
    assign cache_idx = cache_off[CACHE_AW-1:0];
    assign unused_ok = ^{SNES_ADDR[23:10], CORE_CBR_DATA[3:0], CORE_RD_ADDR, CORE_WADDR, cache_off};

    gsu_cache_dp #(.AW(CACHE_AW)) u_cache (
        .clk     (CLK),
        .a_we    (cache_wr),
        .a_addr  (cache_idx),
        .a_wdata (DATA_IN),
        .a_rdata (cache_a_rdata),
        .b_addr  (CACHE_CORE_ADDR),
        .b_rdata (CACHE_CORE_RDATA)
    );

    always_comb begin
        reg_rdata = 8'h00;
        if (is_gpr) begin
            reg_rdata = addr[0] ? gpr[gpr_idx][15:8] : gpr[gpr_idx][7:0];
        end else begin
            case (addr)
                ADDR_SFR_L: reg_rdata = sfr[7:0];
                ADDR_SFR_H: reg_rdata = sfr[15:8];
                ADDR_BRAMR: reg_rdata = bramr;
                ADDR_PBR:   reg_rdata = pbr_r;
                ADDR_ROMBR: reg_rdata = rombr;
                ADDR_CFGR:  reg_rdata = cfgr;
                ADDR_SCBR:  reg_rdata = scbr;
                ADDR_CLSR:  reg_rdata = clsr;
                ADDR_SCMR:  reg_rdata = scmr;
                ADDR_VCR:   reg_rdata = VCR_VALUE;
                ADDR_RAMBR: reg_rdata = rambr;
                ADDR_CBR_L: reg_rdata = cbr_r[7:0];
                ADDR_CBR_H: reg_rdata = cbr_r[15:8];
                default:    reg_rdata = 8'h00;
            endcase
        end
    end

    // Later assignments win: STOP overrides SNES SFR writes and the read-clear of bit 15.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            sfr <= '0; cbr_r <= '0; wr_flop <= '0;
            bramr <= '0; pbr_r <= '0; rombr <= '0; cfgr <= '0;
            scbr <= '0; clsr <= '0; scmr <= '0; rambr <= '0;
            data_out <= 8'h00; cache_blocked <= 1'b0;
        end else begin
            if (gpr_wr) begin
                if (!addr[0]) begin
                    wr_flop <= DATA_IN;
                end else begin
                    gpr[gpr_idx] <= {DATA_IN, wr_flop};
                    if (addr == ADDR_R15_HI) sfr[SFR_GO] <= 1'b1;
                end
            end
            if (snes_wr) begin
                case (addr)
                    ADDR_SFR_L: sfr[6:1] <= DATA_IN[6:1];
                    ADDR_SFR_H: begin
                        sfr[15]   <= DATA_IN[7];
                        sfr[12:8] <= DATA_IN[4:0];
                    end
                    ADDR_BRAMR: bramr <= DATA_IN;
                    ADDR_PBR:   pbr_r <= DATA_IN;
                    ADDR_ROMBR: rombr <= DATA_IN;
                    ADDR_CFGR:  cfgr  <= DATA_IN;
                    ADDR_SCBR:  scbr  <= DATA_IN;
                    ADDR_CLSR:  clsr  <= DATA_IN;
                    ADDR_SCMR:  scmr  <= DATA_IN;
                    ADDR_RAMBR: rambr <= DATA_IN;
                    default: ;
                endcase
            end
            if (CORE_WE && sfr[SFR_GO]) gpr[CORE_WADDR[GW-1:0]] <= CORE_WDATA;
            if (CORE_CBR_WE) cbr_r <= {CORE_CBR_DATA[15:4], 4'h0};
            if (rd_accept && addr == ADDR_SFR_H) sfr[SFR_IRQ] <= 1'b0;
            if (CORE_STOP) begin
                sfr[SFR_GO]  <= 1'b0;
                sfr[SFR_IRQ] <= 1'b1;
            end
            if (rd_accept) begin
                data_out      <= is_cache ? 8'h00 : reg_rdata;
                cache_blocked <= sfr[SFR_GO];
            end else if (state == RD_CACHE) begin
                data_out <= cache_blocked ? 8'h00 : cache_a_rdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= RD_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RD_IDLE:  if (rd_accept) state_nx = is_cache ? RD_CACHE : RD_REG;
            RD_CACHE: state_nx = RD_HOLD;
            RD_REG:   state_nx = RD_HOLD;
            RD_HOLD:  if (!ENABLE) state_nx = RD_IDLE;
            default:  state_nx = RD_IDLE;
        endcase
        if (SNES_WR_end) state_nx = RD_IDLE;
    end

    assign DATA_ENABLE  = (state != RD_IDLE);
    assign DATA_OUT     = data_out;
    assign CORE_RD_DATA = gpr[CORE_RD_ADDR[GW-1:0]];
    assign GO           = sfr[SFR_GO];
    assign IRQ          = sfr[SFR_IRQ] & ~cfgr[CFGR_IRQ_MASK];
    assign PBR          = pbr_r;
    assign CBR          = cbr_r;
endmodule

// File: tb/tb_gsu_mmio.sv
// tb/tb_gsu_mmio.sv - scoreboard bench for gsu_mmio
module tb_gsu_mmio;
    logic        CLK = 1'b0;
    logic        RST, ENABLE, SNES_RD_start, SNES_WR_end;
    logic [23:0] SNES_ADDR;
    logic [7:0]  DATA_IN, DATA_OUT, CACHE_CORE_RDATA, PBR;
    logic        DATA_ENABLE, CORE_WE, CORE_CBR_WE, CORE_STOP, GO, IRQ;
    logic [3:0]  CORE_RD_ADDR, CORE_WADDR;
    logic [15:0] CORE_RD_DATA, CORE_WDATA, CORE_CBR_DATA, CBR;
    logic [8:0]  CACHE_CORE_ADDR;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] m_gpr[16];
    logic [31:0] rnd;

    always #5 CLK = ~CLK;

    gsu_mmio #(.NUM_GPR(16), .CACHE_AW(9)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .SNES_RD_start(SNES_RD_start),
        .SNES_WR_end(SNES_WR_end), .SNES_ADDR(SNES_ADDR), .DATA_IN(DATA_IN),
        .DATA_ENABLE(DATA_ENABLE), .DATA_OUT(DATA_OUT),
        .CORE_RD_ADDR(CORE_RD_ADDR), .CORE_RD_DATA(CORE_RD_DATA),
        .CORE_WE(CORE_WE), .CORE_WADDR(CORE_WADDR), .CORE_WDATA(CORE_WDATA),
        .CORE_CBR_WE(CORE_CBR_WE), .CORE_CBR_DATA(CORE_CBR_DATA), .CORE_STOP(CORE_STOP),
        .CACHE_CORE_ADDR(CACHE_CORE_ADDR), .CACHE_CORE_RDATA(CACHE_CORE_RDATA),
        .GO(GO), .IRQ(IRQ), .PBR(PBR), .CBR(CBR)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic snes_write(input logic [9:0] a, input logic [7:0] d);
        SNES_ADDR = {14'h0, a}; DATA_IN = d; ENABLE = 1'b1; SNES_WR_end = 1'b1;
        step();
        SNES_WR_end = 1'b0; ENABLE = 1'b0;
    endtask

    task automatic gpr_write(input int idx, input logic [15:0] v);
        snes_write(10'(2 * idx), v[7:0]);
        snes_write(10'(2 * idx + 1), v[15:8]);
        m_gpr[idx] = v;
    endtask

    task automatic core_gpr(input string tag, input int idx);
        CORE_RD_ADDR = 4'(idx);
        #1;
        check_val(tag, CORE_RD_DATA, m_gpr[idx]);
    endtask

    task automatic snes_read(input string tag, input logic [9:0] a, input logic [7:0] exp, input bit stop);
        bit cache;
        logic [7:0] e;
        int k;
        cache = (a >= 10'h100) && (a <= 10'h2FF);
        exp_q.push_back(exp);
        SNES_ADDR = {14'h0, a}; ENABLE = 1'b1; SNES_RD_start = 1'b1; CORE_STOP = stop;
        step();
        SNES_RD_start = 1'b0; CORE_STOP = 1'b0;
        @(negedge CLK);
        check_val({tag, "_de"}, DATA_ENABLE, 1);
        if (cache) begin
            check_val({tag, "_n1"}, DATA_OUT, 0);
            step();
            @(negedge CLK);
        end
        e = exp_q.pop_front();
        check_val(tag, DATA_OUT, e);
        ENABLE = 1'b0;
        k = 0;
        while (DATA_ENABLE && k < 4) begin
            step();
            @(negedge CLK);
            k++;
        end
        check_val({tag, "_rel"}, DATA_ENABLE, 0);
    endtask

    task automatic core_stop();
        CORE_STOP = 1'b1;
        step();
        CORE_STOP = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; ENABLE = 0; SNES_RD_start = 0; SNES_WR_end = 0; SNES_ADDR = '0; DATA_IN = '0;
        CORE_RD_ADDR = '0; CORE_WE = 0; CORE_WADDR = '0; CORE_WDATA = '0;
        CORE_CBR_WE = 0; CORE_CBR_DATA = '0; CORE_STOP = 0; CACHE_CORE_ADDR = '0;
        for (int i = 0; i < 16; i++) m_gpr[i] = 16'h0;
        step(); step();
        RST = 1'b0;
        @(negedge CLK);
        check_val("rst_de", DATA_ENABLE, 0);
        check_val("rst_dout", DATA_OUT, 0);
        check_val("rst_go", GO, 0);
        check_val("rst_irq", IRQ, 0);
        check_val("rst_cbr", CBR, 0);
        core_gpr("rst_r0", 0);

        snes_read("vcr", 10'h03B, 8'h04, 0);
        snes_read("sfr_lo_rst", 10'h030, 8'h00, 0);
        snes_read("unmapped", 10'h032, 8'h00, 0);

        gpr_write(0, 16'h1234);
        snes_read("r0_lo", 10'h000, 8'h34, 0);
        snes_read("r0_hi", 10'h001, 8'h12, 0);
        core_gpr("core_r0", 0);
        for (int i = 3; i < 8; i++) begin
            rnd = $urandom;
            gpr_write(i, rnd[15:0]);
        end
        for (int i = 3; i < 8; i++) core_gpr("core_rn", i);
        snes_read("r5_hi", 10'h00B, m_gpr[5][15:8], 0);

        CORE_CBR_DATA = 16'h001F; CORE_CBR_WE = 1'b1;
        step();
        CORE_CBR_WE = 1'b0;
        @(negedge CLK);
        check_val("cbr_load", CBR, 16'h0010);
        snes_read("cbr_lo", 10'h03E, 8'h10, 0);
        snes_read("cbr_hi", 10'h03F, 8'h00, 0);

        snes_write(10'h100, 8'hAB);
        CACHE_CORE_ADDR = 9'h010;
        step();
        @(negedge CLK);
        check_val("core_cache", CACHE_CORE_RDATA, 8'hAB);
        snes_read("cache_rd", 10'h100, 8'hAB, 0);
        snes_write(10'h2FF, 8'hCD);
        CACHE_CORE_ADDR = 9'h00F;
        step();
        @(negedge CLK);
        check_val("core_cache_wrap", CACHE_CORE_RDATA, 8'hCD);
        snes_read("cache_wrap", 10'h2FF, 8'hCD, 0);
        CACHE_CORE_ADDR = 9'h010;
        snes_write(10'h100, 8'h5E);
        @(negedge CLK);
        check_val("cache_collide_old", CACHE_CORE_RDATA, 8'hAB);
        step();
        @(negedge CLK);
        check_val("cache_collide_new", CACHE_CORE_RDATA, 8'h5E);

        gpr_write(15, 16'h8000);
        @(negedge CLK);
        check_val("go_set", GO, 1);
        snes_write(10'h002, 8'h55);
        snes_write(10'h003, 8'h66);
        core_gpr("go_gpr_drop", 1);
        snes_read("cache_go", 10'h100, 8'h00, 0);
        CORE_WADDR = 4'd2; CORE_WDATA = 16'hBEEF; CORE_WE = 1'b1;
        step();
        CORE_WE = 1'b0;
        m_gpr[2] = 16'hBEEF;
        snes_read("r2_lo", 10'h004, 8'hEF, 0);
        snes_read("r2_hi", 10'h005, 8'hBE, 0);

        core_stop();
        check_val("stop_go", GO, 0);
        check_val("stop_irq", IRQ, 1);
        snes_read("sfr_hi_irq", 10'h031, 8'h80, 0);
        check_val("irq_cleared", IRQ, 0);
        snes_read("sfr_lo_stop", 10'h030, 8'h00, 0);
        CORE_WADDR = 4'd2; CORE_WDATA = 16'h1111; CORE_WE = 1'b1;
        step();
        CORE_WE = 1'b0;
        core_gpr("core_we_idle", 2);

        snes_write(10'h030, 8'hFF);
        @(negedge CLK);
        check_val("sfr_go_wr", GO, 1);
        snes_read("sfr_lo_w", 10'h030, 8'h7E, 0);
        snes_write(10'h037, 8'h80);
        core_stop();
        check_val("mask_go", GO, 0);
        check_val("mask_irq", IRQ, 0);
        snes_read("sfr_hi_masked", 10'h031, 8'h80, 0);
        snes_write(10'h037, 8'h00);
        @(negedge CLK);
        check_val("unmask_irq", IRQ, 0);

        snes_read("stop_vs_rd", 10'h031, 8'h00, 1);
        check_val("stop_vs_rd_irq", IRQ, 1);
        snes_read("sfr_hi_set", 10'h031, 8'h80, 0);
        snes_write(10'h031, 8'hFF);
        @(negedge CLK);
        check_val("sfr_hi_w_irq", IRQ, 1);
        snes_read("sfr_hi_w", 10'h031, 8'h9F, 0);
        snes_read("sfr_hi_clr", 10'h031, 8'h1F, 0);

        SNES_ADDR = {14'h0, 10'h03B}; ENABLE = 1'b1; SNES_RD_start = 1'b1;
        step();
        SNES_RD_start = 1'b0;
        step();
        SNES_ADDR = {14'h0, 10'h034}; DATA_IN = 8'h5A; SNES_WR_end = 1'b1;
        step();
        SNES_WR_end = 1'b0; ENABLE = 1'b0;
        @(negedge CLK);
        check_val("wr_abort_de", DATA_ENABLE, 0);
        check_val("pbr_out", PBR, 8'h5A);
        snes_read("pbr_rd", 10'h034, 8'h5A, 0);

        SNES_ADDR = {14'h0, 10'h03B}; ENABLE = 1'b1; SNES_RD_start = 1'b1;
        step();
        SNES_RD_start = 1'b0; RST = 1'b1;
        step();
        RST = 1'b0; ENABLE = 1'b0;
        @(negedge CLK);
        check_val("rst_mid_rd_de", DATA_ENABLE, 0);
        for (int i = 0; i < 16; i++) m_gpr[i] = 16'h0;
        snes_write(10'h006, 8'h99);
        RST = 1'b1;
        step();
        RST = 1'b0;
        snes_write(10'h007, 8'h12);
        m_gpr[3] = 16'h1200;
        core_gpr("rst_partial_r3", 3);
        core_gpr("rst_r0_clear", 0);
        check_val("rst_pbr", PBR, 8'h00);

        check_val("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gsu_mmio.md
# gsu_mmio

Parametrised SNES-side MMIO front end for the GSU: owns the general-purpose register file, special registers, and the SNES port of the instruction cache. It decodes $3000–$32FF accesses, assembles 16-bit register writes from byte pairs, and enforces GO-state access rules. It also supplies the execution core with a register read/write port, GO/IRQ state and a cache read port. It sits between the MMIO mux and the future GSU execution pipeline.

## Interface
- NUM_GPR, 16, number of 16-bit GPRs (power of two, ≤16); GPR index = ADDR[4:1] masked to log2(NUM_GPR) bits.
- CACHE_AW, 9, cache address width; cache depth = 2^CACHE_AW bytes.
- Clock and reset: one clock, CLK; reset is RST, synchronous and active-high.
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- ENABLE  in  1  MMIO window select ($3000–$32FF decoded upstream).
- SNES_RD_start  in  1  one-cycle SNES read strobe.
- SNES_WR_end  in  1  one-cycle SNES write strobe.
- SNES_ADDR  in  24  SNES address; bits [9:0] used.
- DATA_IN  in  8  SNES write data.
- DATA_ENABLE  out  1  drive DATA_OUT onto the SNES bus.
- DATA_OUT  out  8  read data.
- CORE_RD_ADDR  in  4  core GPR read index.
- CORE_RD_DATA  out  16  combinational GPR read.
- CORE_WE  in  1  core GPR write strobe.
- CORE_WADDR  in  4  core GPR write index.
- CORE_WDATA  in  16  core GPR write data.
- CORE_CBR_WE  in  1  core CBR load.
- CORE_CBR_DATA  in  16  CBR value; bits [3:0] are forced to 0.
- CORE_STOP  in  1  core executed STOP.
- CACHE_CORE_ADDR  in  CACHE_AW  core cache read address.
- CACHE_CORE_RDATA  out  8  core cache data, 1-cycle latency.
- GO  out  1  SFR[5].
- IRQ  out  1  SFR[15] & ~CFGR[7].
- PBR, CBR  out  8, 16  register values for the core.

## Operation
- Map: $3000–$301F GPR, even = low byte, odd = high byte. $3030/31 SFR, $3033 BRAMR, $3034 PBR, $3036 ROMBR, $3037 CFGR, $3038 SCBR, $3039 CLSR, $303A SCMR, $303B VCR (read-only, 4), $303C RAMBR, $303E/3F CBR (read-only). $3100–$32FF cache. Unmapped reads return 0x00; unmapped writes are ignored.
- GPR write: an even-address write stores DATA_IN in the byte flop. An odd-address write loads REG[idx] = {DATA_IN, flop}.
- Writing $301F (R15 high) while GO=0 additionally sets GO.
- SFR writes: low byte bits [6:1]; high byte bits 15 and [12:8]. Writing SFR with bit 5 = 0 clears GO.
- Reading $3031 clears SFR[15] after the data is captured.
- Cache index = (ADDR[9:0] − 0x100 + CBR[CACHE_AW-1:0]) mod 2^CACHE_AW.
- GO=1 restrictions:
  - SNES GPR writes and cache reads/writes are dropped; cache reads return 0x00.
  - SFR and SCMR writes are still accepted.
  - Register reads are allowed.
- CORE_WE is honoured only when GO=1.
- CORE_STOP: clears GO and sets SFR[15].
- Priority:
  - CORE_STOP beats an SNES SFR write on GO and bit 15.
  - Setting SFR[15] beats clearing it by a read.
  - CORE_WE beats an SNES GPR write (already dropped while GO=1).
- Read FSM:
  - IDLE: on SNES_RD_start with ENABLE, go to REG_RD (non-cache) or CACHE_RD.
  - CACHE_RD: one wait cycle, then go to HOLD.
  - REG_RD: go to HOLD.
  - HOLD: stay while ENABLE=1; go to IDLE when ENABLE=0.
  - A write strobe received in any state forces IDLE.
- Reset: all GPRs, SFR, BRAMR, PBR, ROMBR, CFGR, SCBR, CLSR, SCMR, RAMBR, CBR and the flop = 0; VCR = 4; FSM = IDLE; DATA_ENABLE = 0; DATA_OUT = 0x00; GO = 0; IRQ = 0. Cache contents are undefined.
- RST mid-access returns to IDLE in the next cycle with no partial GPR write.

## Timing
- Register read: DATA_ENABLE and DATA_OUT are valid in cycle N+1 after SNES_RD_start in cycle N.
- Cache read: DATA_ENABLE rises at N+1; DATA_OUT is valid at N+2 and is 0x00 at N+1.
- DATA_ENABLE stays high until the cycle after ENABLE falls.
- Writes take effect at N+1. GO changes at N+1 after a $301F write or CORE_STOP.
- The core cache port is independent of SNES traffic; same-address SNES write and core read return the old data.

## Structure
- Package gsu_pkg: ADDR_* offsets, SFR bit indices, VCR_VALUE, read-FSM state enum.
- Sub-module gsu_cache_dp: true dual-port RAM, 2^CACHE_AW × 8, synchronous read. Port A is the SNES side, port B is core read-only.

## Test plan
- After reset, read $303B → 0x04 at N+1; read $3030 → 0x00.
- Write $3000=0x34 then $3001=0x12; read $3000/$3001 → 0x34/0x12; CORE_RD_ADDR=0 → 0x1234.
- Load CBR=0x0010 via the core port. SNES write $3100=0xAB → CACHE_CORE_ADDR=0x010 reads 0xAB. SNES read $3100 → 0xAB at N+2.
- Write $301E/$301F → GO=1. SNES write $3002/$3003 is ignored. CORE_WE R2=0xBEEF → $3004 reads 0xEF.
- With GO=1 and CFGR=0: CORE_STOP → GO=0, IRQ=1. Read $3031 → bit7=1, then IRQ=0. With CFGR[7]=1, IRQ stays 0.
- CORE_STOP in the same cycle as a $3031 read → SFR[15] remains 1.
